// File: rtl/dl_loader_pkg.sv
// Shared types and helpers for the download loader.
//   state_t     : loader FSM states
//   slot_field  : extracts the menu slot number from ioctl_index
package dl_loader_pkg;

    localparam int unsigned SLOT_FIELD_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PATCH  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // Bits [7:6] of the index carry a file-extension number and never select a slot.
    function automatic logic [SLOT_FIELD_W-1:0] slot_field(input logic [7:0] index);
        return index[SLOT_FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/dl_ptr_writer.sv
// End-pointer byte sequencer used after a download completes.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, latches value and begins the sequence
//   value      : pointer value, written little-endian
//   wr_c       : current byte is valid (one cycle per byte)
//   addr_c     : PTR_ADDR + byte index
//   data_c     : current pointer byte
//   done_c     : one idle cycle after the last byte, sequence ends
module dl_ptr_writer #(
    parameter int unsigned       ADDR_W    = 25,
    parameter int unsigned       PTR_BYTES = 2,
    parameter logic [ADDR_W-1:0] PTR_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*PTR_BYTES-1:0] value,
    output logic                   wr_c,
    output logic [ADDR_W-1:0]      addr_c,
    output logic [7:0]             data_c,
    output logic                   done_c
);

    localparam int unsigned CNT_W = $clog2(PTR_BYTES + 1);

    logic                   active;
    logic [CNT_W-1:0]       cnt;
    logic [8*PTR_BYTES-1:0] val;

    // Byte counter runs 0..PTR_BYTES; the final count is the idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            val    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            val    <= value;
        end else if (active) begin
            if (cnt == CNT_W'(PTR_BYTES)) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        data_c = '0;
        for (int unsigned i = 0; i < PTR_BYTES; i++) begin
            if (cnt == CNT_W'(i)) begin
                data_c = val[i*8 +: 8];
            end
        end
        wr_c   = active && (cnt < CNT_W'(PTR_BYTES));
        done_c = active && (cnt == CNT_W'(PTR_BYTES));
        addr_c = PTR_ADDR + ADDR_W'(cnt);
    end

endmodule

// File: rtl/dl_loader.sv
// Routes I/O-controller downloads into SDRAM slots and optionally writes an
// end pointer after the file.
//   clk, reset     : clock, synchronous active-high reset
//   ioctl_download : download in progress
//   ioctl_index    : [5:0] slot, [7:6] extension (ignored)
//   ioctl_addr     : byte offset in file
//   ioctl_dout     : byte data
//   ioctl_wr       : byte strobe
//   wr/addr/data   : SDRAM write port
//   downloading    : loader owns memory
//   rom_done       : slot 0 completed at least once (sticky)
//   slot_loaded    : per-slot completion flags (sticky)
//   overflow       : a byte exceeded its slot size (cleared at download start)
module dl_loader
    import dl_loader_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 25,
    parameter int unsigned             NSLOT     = 4,
    parameter logic [NSLOT*ADDR_W-1:0] SLOT_BASE = '0,
    parameter logic [NSLOT*ADDR_W-1:0] SLOT_SIZE = '1,
    parameter logic [NSLOT-1:0]        PATCH_EN  = '0,
    parameter logic [ADDR_W-1:0]       PTR_ADDR  = '0,
    parameter logic [15:0]             PTR_BASE  = '0,
    parameter int unsigned             PTR_BYTES = 2,
    parameter int unsigned             SETTLE    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              downloading,
    output logic              rom_done,
    output logic [NSLOT-1:0]  slot_loaded,
    output logic              overflow
);

    localparam int unsigned PTR_W    = 8 * PTR_BYTES;
    localparam int unsigned SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t                  state;
    logic                    dl_prev;
    logic                    rearm;
    logic [SLOT_FIELD_W-1:0] slot;
    logic [ADDR_W-1:0]       len;
    logic [SETTLE_W-1:0]     settle_cnt;

    logic [ADDR_W-1:0] cur_base_c;
    logic [ADDR_W-1:0] cur_size_c;
    logic              cur_patch_c;
    logic [NSLOT-1:0]  slot_hot_c;
    logic              slot_ok_c;
    logic              dl_rise_c;
    logic              dl_fall_c;
    logic [ADDR_W-1:0] addr_end_c;
    logic              patch_go_c;
    logic              ptr_start_c;
    logic [PTR_W-1:0]  ptr_value_c;
    logic              ptr_wr_c;
    logic [ADDR_W-1:0] ptr_addr_c;
    logic [7:0]        ptr_data_c;
    logic              ptr_done_c;
    logic              unused_ext;

    assign unused_ext = ^ioctl_index[7:6];

    // Per-slot parameters for the latched slot; all zero for an invalid slot.
    always_comb begin
        cur_base_c  = '0;
        cur_size_c  = '0;
        cur_patch_c = 1'b0;
        slot_hot_c  = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (slot == SLOT_FIELD_W'(i)) begin
                cur_base_c    = SLOT_BASE[i*ADDR_W +: ADDR_W];
                cur_size_c    = SLOT_SIZE[i*ADDR_W +: ADDR_W];
                cur_patch_c   = PATCH_EN[i];
                slot_hot_c[i] = 1'b1;
            end
        end
    end

    // rearm makes a download still high on return to IDLE count as a new edge.
    always_comb begin
        slot_ok_c   = |slot_hot_c;
        dl_rise_c   = ioctl_download && (!dl_prev || rearm);
        dl_fall_c   = !ioctl_download && dl_prev;
        addr_end_c  = ioctl_addr + ADDR_W'(1);
        patch_go_c  = slot_ok_c && cur_patch_c && (len != '0);
        ptr_start_c = (state == ST_LOAD) && dl_fall_c && patch_go_c;
        ptr_value_c = PTR_W'(len) + PTR_W'(PTR_BASE);
    end

    dl_ptr_writer #(
        .ADDR_W    (ADDR_W),
        .PTR_BYTES (PTR_BYTES),
        .PTR_ADDR  (PTR_ADDR)
    ) u_ptr_writer (
        .clk    (clk),
        .reset  (reset),
        .start  (ptr_start_c),
        .value  (ptr_value_c),
        .wr_c   (ptr_wr_c),
        .addr_c (ptr_addr_c),
        .data_c (ptr_data_c),
        .done_c (ptr_done_c)
    );

    // Loader FSM with registered SDRAM port and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            dl_prev     <= 1'b0;
            rearm       <= 1'b0;
            slot        <= '0;
            len         <= '0;
            settle_cnt  <= '0;
            wr          <= 1'b0;
            addr        <= '0;
            data        <= '0;
            downloading <= 1'b0;
            rom_done    <= 1'b0;
            slot_loaded <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            rearm   <= 1'b0;
            wr      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dl_rise_c) begin
                        state       <= ST_LOAD;
                        slot        <= slot_field(ioctl_index);
                        len         <= '0;
                        overflow    <= 1'b0;
                        downloading <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (dl_fall_c) begin
                        state      <= patch_go_c ? ST_PATCH : ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (ioctl_wr && slot_ok_c) begin
                        if (ioctl_addr < cur_size_c) begin
                            wr   <= 1'b1;
                            addr <= cur_base_c + ioctl_addr;
                            data <= ioctl_dout;
                            if (addr_end_c > len) begin
                                len <= addr_end_c;
                            end
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_PATCH: begin
                    if (ptr_wr_c) begin
                        wr   <= 1'b1;
                        addr <= ptr_addr_c;
                        data <= ptr_data_c;
                    end
                    if (ptr_done_c) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE - 1)) begin
                        state       <= ST_IDLE;
                        downloading <= 1'b0;
                        rearm       <= 1'b1;
                        slot_loaded <= slot_loaded | slot_hot_c;
                        if (slot_hot_c[0]) begin
                            rom_done <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
